// File: rtl/board_pkg.sv
// Shared types and default geometry for the drop_board playfield.
//   state_e : top-level FSM states (idle / piece falling)
//   piece_e : piece colour, encoded to match the player input (0 = red, 1 = green)
package board_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StFall = 1'b1
    } state_e;

    typedef enum logic {
        PieceRed = 1'b0,
        PieceGrn = 1'b1
    } piece_e;

    localparam int unsigned DefaultCols    = 16;
    localparam int unsigned DefaultRows    = 16;
    localparam int unsigned DefaultDropDiv = 4;

endpackage

// File: rtl/drop_column.sv
// One playfield column: stack height plus the committed red/green pieces.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   commit_i      : place one piece of colour_i on top of the stack
//   height_o      : number of pieces held (0..ROWS)
//   full_o        : column holds ROWS pieces
//   red_o, grn_o  : committed pieces, bit 0 = bottom row
module drop_column
    import board_pkg::*;
#(
    parameter int unsigned ROWS = DefaultRows,
    localparam int unsigned HgtW = $clog2(ROWS + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            commit_i,
    input  piece_e          colour_i,
    output logic [HgtW-1:0] height_o,
    output logic            full_o,
    output logic [ROWS-1:0] red_o,
    output logic [ROWS-1:0] grn_o
);

    logic [HgtW-1:0] height_q, height_d;
    logic [ROWS-1:0] red_q, red_d, grn_q, grn_d;
    logic [ROWS-1:0] slot;

    assign full_o = (height_q == HgtW'(ROWS));
    // One-hot mask of the first free cell.
    assign slot   = ROWS'(1) << height_q;

    always_comb begin
        height_d = height_q;
        red_d    = red_q;
        grn_d    = grn_q;
        if (commit_i && !full_o) begin
            height_d = height_q + HgtW'(1);
            if (colour_i == PieceGrn) begin
                grn_d = grn_q | slot;
            end else begin
                red_d = red_q | slot;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            height_q <= '0;
            red_q    <= '0;
            grn_q    <= '0;
        end else begin
            height_q <= height_d;
            red_q    <= red_d;
            grn_q    <= grn_d;
        end
    end

    assign height_o = height_q;
    assign red_o    = red_q;
    assign grn_o    = grn_q;

endmodule

// File: rtl/drop_board.sv
// Connect-Four playfield with gravity animation.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   col_sel_i            : target column (binary, 0 = leftmost)
//   drop_req_i, player_i : drop request and colour (0 red, 1 green), sampled in idle
//   busy_o               : a piece is falling
//   drop_done_o          : one-cycle pulse after the piece is committed
//   drop_reject_o        : one-cycle pulse after a refused request
//   board_full_o         : every column holds ROWS pieces
//   red_pixels_o         : [column][row] red LEDs, committed pieces plus falling piece
//   grn_pixels_o         : same layout for green
module drop_board
    import board_pkg::*;
#(
    parameter int unsigned COLS     = DefaultCols,
    parameter int unsigned ROWS     = DefaultRows,
    parameter int unsigned DROP_DIV = DefaultDropDiv,
    localparam int unsigned COL_W   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [COL_W-1:0]          col_sel_i,
    input  logic                      drop_req_i,
    input  logic                      player_i,
    output logic                      busy_o,
    output logic                      drop_done_o,
    output logic                      drop_reject_o,
    output logic                      board_full_o,
    output logic [COLS-1:0][ROWS-1:0] red_pixels_o,
    output logic [COLS-1:0][ROWS-1:0] grn_pixels_o
);

    localparam int unsigned HgtW = $clog2(ROWS + 1);
    localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned DivW = (DROP_DIV > 1) ? $clog2(DROP_DIV) : 1;

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    piece_e           piece_q, piece_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [DivW-1:0]  div_q, div_d;
    logic             done_q, done_d, reject_q, reject_d;

    logic [COLS-1:0]           commit, col_full;
    logic [COLS-1:0][HgtW-1:0] heights;
    logic [COLS-1:0][ROWS-1:0] red_cm, grn_cm;
    logic [HgtW-1:0]           sel_hgt, cur_hgt;
    logic                      sel_valid, step, landing;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        drop_column #(
            .ROWS(ROWS)
        ) u_col (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .commit_i(commit[c]),
            .colour_i(piece_q),
            .height_o(heights[c]),
            .full_o  (col_full[c]),
            .red_o   (red_cm[c]),
            .grn_o   (grn_cm[c])
        );
    end

    // Height lookup by comparison so an out-of-range col_sel_i never indexes past COLS.
    always_comb begin
        sel_hgt = '0;
        cur_hgt = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (32'(col_sel_i) == c) sel_hgt = heights[c];
            if (32'(col_q) == c)     cur_hgt = heights[c];
        end
    end

    assign sel_valid = (32'(col_sel_i) < COLS);
    assign step      = (div_q == DivW'(DROP_DIV - 1));
    assign landing   = (HgtW'(row_q) == cur_hgt);

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        piece_d  = piece_q;
        row_d    = row_q;
        div_d    = div_q;
        done_d   = 1'b0;
        reject_d = 1'b0;
        commit   = '0;
        unique case (state_q)
            StIdle: begin
                if (drop_req_i) begin
                    if (sel_valid && (sel_hgt != HgtW'(ROWS))) begin
                        col_d   = col_sel_i;
                        piece_d = piece_e'(player_i);
                        row_d   = RowW'(ROWS - 1);
                        div_d   = '0;
                        state_d = StFall;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            StFall: begin
                if (step) begin
                    div_d = '0;
                    if (landing) begin
                        commit[col_q] = 1'b1;
                        done_d        = 1'b1;
                        state_d       = StIdle;
                    end else begin
                        row_d = row_q - RowW'(1);
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            col_q    <= '0;
            piece_q  <= PieceRed;
            row_q    <= '0;
            div_q    <= '0;
            done_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            piece_q  <= piece_d;
            row_q    <= row_d;
            div_q    <= div_d;
            done_q   <= done_d;
            reject_q <= reject_d;
        end
    end

    // The falling piece is always above the stack, so it never overlaps a committed cell.
    always_comb begin
        red_pixels_o = red_cm;
        grn_pixels_o = grn_cm;
        if (state_q == StFall) begin
            if (piece_q == PieceGrn) begin
                grn_pixels_o[col_q][row_q] = 1'b1;
            end else begin
                red_pixels_o[col_q][row_q] = 1'b1;
            end
        end
    end

    assign busy_o        = (state_q == StFall);
    assign drop_done_o   = done_q;
    assign drop_reject_o = reject_q;
    assign board_full_o  = &col_full;

endmodule

// File: tb/tb_drop_board.sv
// Bench for drop_board: three instances (16x16/4, 7x6/1, 4x8/2) checked against
// a per-column height/colour model and hand-computed vectors.
module tb_drop_board;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: defaults
    logic [3:0]        a_col;
    logic              a_req, a_pl, a_busy, a_done, a_rej, a_full;
    logic [15:0][15:0] a_red, a_grn;
    // Instance B: 7 columns x 6 rows, one clock per step
    logic [2:0]        b_col;
    logic              b_req, b_pl, b_busy, b_done, b_rej, b_full;
    logic [6:0][5:0]   b_red, b_grn;
    // Instance C: 4 columns x 8 rows, two clocks per step
    logic [1:0]        c_col;
    logic              c_req, c_pl, c_busy, c_done, c_rej, c_full;
    logic [3:0][7:0]   c_red, c_grn;

    drop_board u_a (
        .clk_i(clk), .rst_ni(rst_n), .col_sel_i(a_col), .drop_req_i(a_req), .player_i(a_pl),
        .busy_o(a_busy), .drop_done_o(a_done), .drop_reject_o(a_rej), .board_full_o(a_full),
        .red_pixels_o(a_red), .grn_pixels_o(a_grn)
    );

    drop_board #(.COLS(7), .ROWS(6), .DROP_DIV(1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .col_sel_i(b_col), .drop_req_i(b_req), .player_i(b_pl),
        .busy_o(b_busy), .drop_done_o(b_done), .drop_reject_o(b_rej), .board_full_o(b_full),
        .red_pixels_o(b_red), .grn_pixels_o(b_grn)
    );

    drop_board #(.COLS(4), .ROWS(8), .DROP_DIV(2)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .col_sel_i(c_col), .drop_req_i(c_req), .player_i(c_pl),
        .busy_o(c_busy), .drop_done_o(c_done), .drop_reject_o(c_rej), .board_full_o(c_full),
        .red_pixels_o(c_red), .grn_pixels_o(c_grn)
    );

    // Reference model: stack height and committed colours per column.
    int          ha [16];
    logic [15:0] ra_m [16];
    logic [15:0] ga_m [16];
    int          hb [7];
    logic [5:0]  rb_m [7];
    logic [5:0]  gb_m [7];

    typedef struct {
        int          col;
        bit          pl;
        int          lat;
        logic [15:0] red;
        logic [15:0] grn;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] a_pack(input bit grn);
        logic [255:0] v = '0;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = grn ? ga_m[i] : ra_m[i];
        return v;
    endfunction

    function automatic logic [255:0] b_pack(input bit grn);
        logic [255:0] v = '0;
        for (int i = 0; i < 7; i++) v[i*6 +: 6] = grn ? gb_m[i] : rb_m[i];
        return v;
    endfunction

    task automatic models_reset();
        for (int i = 0; i < 16; i++) begin
            ha[i] = 0; ra_m[i] = '0; ga_m[i] = '0;
        end
        for (int i = 0; i < 7; i++) begin
            hb[i] = 0; rb_m[i] = '0; gb_m[i] = '0;
        end
    endtask

    // Present a request on A and sample the cycle after the accept/reject edge.
    task automatic a_issue(input int col, input bit pl, input bit hold, output bit acc);
        logic [15:0] top;
        a_col = 4'(col);
        a_pl  = pl;
        a_req = 1'b1;
        @(negedge clk);
        if (!hold) a_req = 1'b0;
        if (ha[col] == 16) begin
            acc = 1'b0;
            chk("a_reject", a_rej, 1);
            chk("a_reject_busy", a_busy, 0);
            @(negedge clk);
            chk("a_reject_one_cycle", a_rej, 0);
            chk("a_reject_busy_after", a_busy, 0);
            chk("a_reject_red_unchanged", a_red, a_pack(0));
            chk("a_reject_grn_unchanged", a_grn, a_pack(1));
        end else begin
            acc = 1'b1;
            chk("a_accept_busy", a_busy, 1);
            chk("a_accept_no_reject", a_rej, 0);
            top = pl ? ga_m[col] : ra_m[col];
            top[15] = 1'b1;
            chk("a_piece_at_top", pl ? a_grn[col] : a_red[col], top);
        end
    endtask

    // Wait for drop_done on A; optionally pulse a stray request at fall cycle pulse_at.
    task automatic a_finish(input int col, input bit pl, input int pulse_at, output int lat);
        int k = 0;
        bit seen_rej = 1'b0;
        int exp_lat = (16 - ha[col]) * 4;
        while (!a_done && k < 2000) begin
            if (pulse_at >= 0) begin
                a_req = (k == pulse_at);
                a_col = 4'((col + 5) % 16);
            end
            @(negedge clk);
            k++;
            if (a_rej) seen_rej = 1'b1;
        end
        if (pulse_at >= 0) a_req = 1'b0;
        lat = k;
        if (pl) ga_m[col][ha[col]] = 1'b1;
        else    ra_m[col][ha[col]] = 1'b1;
        ha[col]++;
        chk("a_done_latency", 32'(k), 32'(exp_lat));
        chk("a_done_busy_low", a_busy, 0);
        chk("a_fall_no_reject", seen_rej, 0);
        chk("a_red_board", a_red, a_pack(0));
        chk("a_grn_board", a_grn, a_pack(1));
    endtask

    initial begin
        vec_t vt [5];
        bit   acc;
        int   lat, c, k, filled;
        logic [15:0] top;

        vt[0] = '{3, 1'b0, 64, 16'h0001, 16'h0000};
        vt[1] = '{3, 1'b1, 60, 16'h0001, 16'h0002};
        vt[2] = '{0, 1'b1, 64, 16'h0000, 16'h0001};
        vt[3] = '{3, 1'b0, 56, 16'h0005, 16'h0002};
        vt[4] = '{15, 1'b1, 64, 16'h0000, 16'h0001};

        rst_n = 1'b0;
        a_req = 0; a_col = '0; a_pl = 0;
        b_req = 0; b_col = '0; b_pl = 0;
        c_req = 0; c_col = '0; c_pl = 0;
        models_reset();
        repeat (3) @(negedge clk);
        chk("reset_a_red", a_red, '0);
        chk("reset_a_grn", a_grn, '0);
        chk("reset_a_busy", a_busy, 0);
        chk("reset_a_done", a_done, 0);
        chk("reset_a_reject", a_rej, 0);
        chk("reset_a_full", a_full, 0);
        chk("reset_b_full", b_full, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven single drops.
        for (int i = 0; i < 5; i++) begin
            a_issue(vt[i].col, vt[i].pl, 1'b0, acc);
            a_finish(vt[i].col, vt[i].pl, -1, lat);
            chk("vec_latency", 32'(lat), 32'(vt[i].lat));
            chk("vec_red_col", a_red[vt[i].col], vt[i].red);
            chk("vec_grn_col", a_grn[vt[i].col], vt[i].grn);
        end

        // Random drops against the model.
        repeat (12) begin
            c = $urandom_range(0, 14);
            k = $urandom_range(0, 1);
            a_issue(c, k[0], 1'b0, acc);
            if (acc) a_finish(c, k[0], -1, lat);
        end

        // Request held through the commit edge: taken one edge later.
        a_issue(5, 1'b1, 1'b1, acc);
        a_finish(5, 1'b1, -1, lat);
        @(negedge clk);
        a_req = 1'b0;
        chk("held_req_accepted", a_busy, 1);
        top = ga_m[5];
        top[15] = 1'b1;
        chk("held_req_piece_top", a_grn[5], top);
        a_finish(5, 1'b1, -1, lat);

        // Stray request mid-fall is ignored.
        a_issue(7, 1'b0, 1'b0, acc);
        a_finish(7, 1'b0, 10, lat);
        @(negedge clk);
        chk("stray_req_not_latched", a_busy, 0);

        // Fill column 15, then one more request.
        while (ha[15] < 16) begin
            k = $urandom_range(0, 1);
            a_issue(15, k[0], 1'b0, acc);
            a_finish(15, k[0], -1, lat);
        end
        a_issue(15, 1'b0, 1'b0, acc);
        chk("full_col_refused", acc, 0);

        // Reset in the middle of a fall.
        a_issue(9, 1'b1, 1'b0, acc);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midfall_rst_red", a_red, '0);
        chk("midfall_rst_grn", a_grn, '0);
        chk("midfall_rst_busy", a_busy, 0);
        chk("midfall_rst_full", a_full, 0);
        models_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_issue(9, 1'b0, 1'b0, acc);
        a_finish(9, 1'b0, -1, lat);
        chk("post_rst_lands_row0", a_red[9], 16'h0001);

        // Small board: out-of-range column, then fill all 42 cells.
        b_col = 3'd7; b_req = 1'b1;
        @(negedge clk);
        b_req = 1'b0;
        chk("b_col7_reject", b_rej, 1);
        chk("b_col7_busy", b_busy, 0);
        @(negedge clk);
        chk("b_col7_reject_one_cycle", b_rej, 0);
        filled = 0;
        while (filled < 42) begin
            c = $urandom_range(0, 6);
            if (hb[c] == 6) continue;
            k = $urandom_range(0, 1);
            b_col = 3'(c); b_pl = k[0]; b_req = 1'b1;
            @(negedge clk);
            b_req = 1'b0;
            chk("b_accept_busy", b_busy, 1);
            lat = 0;
            while (!b_done && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            chk("b_latency", 32'(lat), 32'(6 - hb[c]));
            if (k[0]) gb_m[c][hb[c]] = 1'b1;
            else      rb_m[c][hb[c]] = 1'b1;
            hb[c]++;
            filled++;
            chk("b_red_board", b_red, b_pack(0));
            chk("b_grn_board", b_grn, b_pack(1));
            chk("b_board_full", b_full, (filled == 42) ? 1 : 0);
        end
        for (int i = 0; i < 8; i++) begin
            b_col = 3'(i); b_req = 1'b1;
            @(negedge clk);
            b_req = 1'b0;
            chk("b_full_reject", b_rej, 1);
            chk("b_full_busy", b_busy, 0);
        end
        chk("b_full_red_unchanged", b_red, b_pack(0));

        // Falling-piece trace on C: one lit cell, moving down every 2 cycles.
        c_col = 2'd2; c_pl = 1'b1; c_req = 1'b1;
        @(negedge clk);
        c_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("c_trace_grn", c_grn, 32'(1) << (16 + 7 - i / 2));
            chk("c_trace_red", c_red, '0);
            chk("c_trace_busy", c_busy, 1);
            @(negedge clk);
        end
        chk("c_trace_done", c_done, 1);
        chk("c_trace_busy_low", c_busy, 0);
        chk("c_trace_committed", c_grn, 32'h0001_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/drop_board.md
# drop_board

Parametrised Connect-Four playfield with gravity animation: accepts a binary column select and a drop request, animates the piece falling one row per DROP_DIV clocks, commits it on the stack in that column, and drives the red/green LED pixel arrays. It replaces the fixed 16x16 one-hot board. It sits between the game controller (turn/win logic) and the LED matrix driver. It adds a busy/done/reject handshake and a board-full flag.

## Interface
- COLS, default 16: number of columns.
- ROWS, default 16: number of rows per column.
- DROP_DIV, default 4: clocks per one-row fall step; must be ≥ 1.
- COL_W, localparam $clog2(COLS): column-select width.

- clk  in  1  system clock; all state updates on its rising edge.
- RST  in  1  one clock; reset is asynchronous and active-low (0 = reset).
- col_sel  in  COL_W  target column, binary; 0 is leftmost.
- drop_req  in  1  request a drop; sampled only in IDLE.
- player  in  1  0 = red piece, 1 = green piece; sampled with drop_req.
- busy  out  1  high while a piece is falling.
- drop_done  out  1  one-cycle pulse when the piece is committed.
- drop_reject  out  1  one-cycle pulse when a request is refused.
- board_full  out  1  high when every column holds ROWS pieces.
- RedPixels  out  [COLS-1:0][ROWS-1:0]  outer index = column; bit 0 = bottom row.
- GrnPixels  out  [COLS-1:0][ROWS-1:0]  same layout as RedPixels.

## Operation
- State per column: height counter (0..ROWS, width $clog2(ROWS+1)) and committed red/green bit vectors.
- FSM states: IDLE, FALL.
- IDLE:
  - drop_req=1 with col_sel<COLS and height[col_sel]<ROWS: latch the column and player, set the piece row to ROWS-1, clear the divider, assert busy, go to FALL.
  - drop_req=1 with col_sel≥COLS or height[col_sel]==ROWS: pulse drop_reject, stay in IDLE, no state change.
- FALL:
  - The divider counts 0..DROP_DIV-1; a step edge occurs when it wraps.
  - On a step edge with piece row > height: decrement the piece row.
  - On a step edge with piece row == height: commit. Set the colour bit at [col][height], increment height, pulse drop_done, go to IDLE.
- Display: pixels show the OR of committed bits and the falling piece. The falling piece appears at [col][row] in red (player 0) or green (player 1). Red and green are never both set on one pixel.
- drop_req during FALL is ignored; no reject is issued.
- board_full is a combinational AND over all columns of (height==ROWS).

## Timing
- Reset values: all pixels 0, heights 0, busy 0, drop_done 0, drop_reject 0, board_full 0, FSM in IDLE.
- Reset asserted mid-FALL aborts the in-flight piece immediately and clears the whole board.
- Accept edge E0: busy=1 and the piece is visible at row ROWS-1 in the cycle after E0.
- Commit edge for landing height h: E0 + (ROWS-h)·DROP_DIV. In the following cycle:
  - the committed pixel is visible;
  - drop_done=1;
  - busy=0.
- drop_reject is high in the cycle after the sampling edge, for exactly one cycle.
- A drop_req held high through the commit edge is not accepted at that edge. It is accepted at the next edge, when the FSM is in IDLE.
- Back-to-back accepts are therefore spaced at least (ROWS-h)·DROP_DIV+1 cycles apart.

## Structure
- Package board_pkg holds:
  - the state enum (IDLE, FALL);
  - the piece-colour enum (RED=0, GRN=1);
  - the default geometry constants.
- Sub-module drop_column, one instance per column via generate:
  - holds the height counter and committed bit vectors;
  - inputs: commit strobe and colour;
  - outputs: height, full flag, red/green vectors.
- The top level owns the FSM, the divider, the falling-piece register and the pixel overlay.

## Test plan
- Reset: pulse RST=0 mid-run → all pixels 0, busy=0, board_full=0, and the next drop lands at row 0.
- Defaults (16x16, DROP_DIV=4), player=0, col_sel=3, empty board → drop_done 64 cycles after accept, RedPixels[3]=16'h0001, busy=0 in the same cycle.
- Follow-up drop with player=1, col_sel=3 → drop_done 60 cycles after accept, GrnPixels[3]=16'h0002, RedPixels[3] unchanged.
- Fill column 15 with 16 drops, then a 17th request → single-cycle drop_reject, no pixel change, busy stays 0; drop_req pulsed during a fall → ignored.
- COLS=7, ROWS=6, DROP_DIV=1: col_sel=7 → drop_reject. Fill all 42 cells → board_full=1 after the last drop_done, and every later request is rejected.
- Falling-piece trace with DROP_DIV=2 into an empty column → the lit row decrements by one every 2 cycles from ROWS-1 to 0, and exactly one pixel in the column is lit during the fall.
